// File: rtl/noc_output_arbiter_if.sv
// Router output-port link bundle: FIFO-side request/data/pop toward the inputs,
// registered flit link plus credit return toward the next hop.
interface noc_output_arbiter_if #(
    parameter int NUM_IN = 4,
    parameter int FLIT_W = 16
);
    logic [NUM_IN-1:0]        req_i;
    logic [NUM_IN*FLIT_W-1:0] data_i;
    logic [NUM_IN-1:0]        shift_o;
    logic [FLIT_W-1:0]        data_o;
    logic                     valid_o;
    logic                     credit_i;
    logic                     busy_o;
    logic                     credit_err_o;

    modport slave (
        input  req_i, data_i, credit_i,
        output shift_o, data_o, valid_o, busy_o, credit_err_o
    );

    modport master (
        output req_i, data_i, credit_i,
        input  shift_o, data_o, valid_o, busy_o, credit_err_o
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// Wormhole round-robin output arbiter: one arbitration cycle, then a pop per cycle with registered output.
// Latency: request -> shift next cycle -> valid_o the cycle after; transfers stall when the credit counter is 0.
module noc_output_arbiter #(
    parameter int NUM_IN  = 4,
    parameter int FLIT_W  = 16,
    parameter int CREDITS = 5
) (
    input  logic clk,
    input  logic rst,
    noc_output_arbiter_if.slave bus
);
    localparam int PTR_W    = $clog2(NUM_IN);
    localparam int CNT_W    = $clog2(CREDITS + 1);
    localparam int HEAD_BIT = 15;
    localparam int TAIL_BIT = 14;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic [FLIT_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [NUM_IN-1:0]  eligible;
    logic [NUM_IN-1:0]  shift;
    logic [FLIT_W-1:0]  grant_flit;
    logic               grant_req;
    logic               found;
    logic [PTR_W-1:0]   pick;
    int                 idx;
    logic               xfer;

    // Only head flits may open a packet; stray body/tail requests are never served.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            eligible[k] = bus.req_i[k] & bus.data_i[k*FLIT_W + HEAD_BIT];
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_flit = '0;
        grant_req  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant_q == PTR_W'(k)) begin
                grant_flit = bus.data_i[k*FLIT_W +: FLIT_W];
                grant_req  = bus.req_i[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        credits_d = credits_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        shift     = '0;
        xfer      = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (grant_req && (credits_q != '0)) begin
                    xfer    = 1'b1;
                    shift   = NUM_IN'(1) << grant_q;
                    data_d  = grant_flit;
                    valid_d = 1'b1;
                    // Only the tail bit releases the lock; a mid-packet head is plain data.
                    if (grant_flit[TAIL_BIT]) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == PTR_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer && !bus.credit_i) begin
            credits_d = credits_q - 1'b1;
        end else if (!xfer && bus.credit_i) begin
            if (credits_q == CNT_W'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            credits_q <= CNT_W'(CREDITS);
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            credits_q <= credits_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign bus.shift_o      = shift;
    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.busy_o       = (state_q == LOCKED);
    assign bus.credit_err_o = err_q;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter: small per-input FIFO model feeds req/data and pops on shift_o.
module tb_noc_output_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NUM_IN(4), .FLIT_W(16)) bus();

    noc_output_arbiter #(.NUM_IN(4), .FLIT_W(16), .CREDITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [4][16];
    int          rd  [4];
    int          wr  [4];

    logic [3:0]  e2_sh   [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic        e2_vld  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] e2_dat  [8] = '{16'h0000, 16'h8001, 16'h0002, 16'h4003, 16'h4003, 16'h8001, 16'h0002, 16'h4003};
    logic        e2_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] e5_dat  [5] = '{16'hC000, 16'hC010, 16'hC020, 16'hC030, 16'hC001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (rd[k] < wr[k]) begin
                bus.req_i[k]            = 1'b1;
                bus.data_i[k*16 +: 16]  = mem[k][rd[k]];
            end else begin
                bus.req_i[k]            = 1'b0;
                bus.data_i[k*16 +: 16]  = 16'h0000;
            end
        end
    endtask

    task automatic push(input int k, input logic [15:0] f);
        mem[k][wr[k]] = f;
        wr[k]++;
    endtask

    task automatic clear_q();
        for (int k = 0; k < 4; k++) begin
            rd[k] = 0;
            wr[k] = 0;
        end
    endtask

    // One clock: pops whatever shift_o requested this cycle, then refreshes the FIFO heads.
    task automatic tick();
        logic [3:0] sh;
        sh = bus.shift_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (sh[k]) rd[k]++;
        end
        bus.credit_i = 1'b0;
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.credit_i = 1'b0;
        clear_q();
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.credit_i = 1'b0;
        clear_q();
        drive();
        #1;
        chk("rst_shift", bus.shift_o, 4'b0000);
        chk("rst_data", bus.data_o, 16'h0000);
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_err", bus.credit_err_o, 1'b0);
        chk("rst_credits", dut.credits_q, 5);
        chk("rst_rr", dut.rr_ptr_q, 0);

        // Single-flit packet on input 2
        do_reset();
        push(2, 16'hC123);
        drive();
        #1;
        chk("t1_arb_shift", bus.shift_o, 4'b0000);
        tick();
        chk("t1_busy", bus.busy_o, 1'b1);
        chk("t1_shift", bus.shift_o, 4'b0100);
        chk("t1_valid_early", bus.valid_o, 1'b0);
        tick();
        chk("t1_valid", bus.valid_o, 1'b1);
        chk("t1_data", bus.data_o, 16'hC123);
        chk("t1_idle", bus.busy_o, 1'b0);
        chk("t1_credits", dut.credits_q, 4);
        chk("t1_rr", dut.rr_ptr_q, 3);
        tick();
        chk("t1_valid_drop", bus.valid_o, 1'b0);
        chk("t1_data_hold", bus.data_o, 16'hC123);

        // Two 3-flit packets competing from reset
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push(k, 16'h8001);
            push(k, 16'h0002);
            push(k, 16'h4003);
        end
        drive();
        #1;
        for (int n = 0; n < 8; n++) begin
            if (n == 4) bus.credit_i = 1'b1;
            tick();
            chk($sformatf("t2_shift%0d", n), bus.shift_o, e2_sh[n]);
            chk($sformatf("t2_valid%0d", n), bus.valid_o, e2_vld[n]);
            chk($sformatf("t2_busy%0d", n), bus.busy_o, e2_busy[n]);
            if (e2_vld[n]) chk($sformatf("t2_data%0d", n), bus.data_o, e2_dat[n]);
        end
        chk("t2_credits", dut.credits_q, 0);

        // Credit exhaustion on a 7-flit packet
        do_reset();
        push(3, 16'h8010);
        for (int i = 1; i < 6; i++) push(3, 16'h0010 + 16'(i));
        push(3, 16'h4016);
        drive();
        #1;
        tick();
        chk("t3_shift_first", bus.shift_o, 4'b1000);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("t3_valid%0d", n), bus.valid_o, 1'b1);
            chk($sformatf("t3_data%0d", n), bus.data_o, (n == 0) ? 16'h8010 : 16'h0010 + 16'(n));
        end
        chk("t3_credits0", dut.credits_q, 0);
        chk("t3_stall_shift0", bus.shift_o, 4'b0000);
        tick();
        chk("t3_stall_valid", bus.valid_o, 1'b0);
        chk("t3_stall_busy", bus.busy_o, 1'b1);
        tick();
        chk("t3_stall_shift1", bus.shift_o, 4'b0000);
        bus.credit_i = 1'b1;
        tick();
        chk("t3_rel_shift", bus.shift_o, 4'b1000);
        chk("t3_rel_credits", dut.credits_q, 1);
        chk("t3_rel_valid0", bus.valid_o, 1'b0);
        tick();
        chk("t3_rel_valid", bus.valid_o, 1'b1);
        chk("t3_rel_data", bus.data_o, 16'h0015);
        chk("t3_rel_shift_off", bus.shift_o, 4'b0000);
        tick();
        chk("t3_rel_valid_off", bus.valid_o, 1'b0);
        bus.credit_i = 1'b1;
        tick();
        chk("t3_rel2_shift", bus.shift_o, 4'b1000);
        tick();
        chk("t3_tail_data", bus.data_o, 16'h4016);
        chk("t3_tail_valid", bus.valid_o, 1'b1);
        chk("t3_tail_idle", bus.busy_o, 1'b0);
        chk("t3_rr", dut.rr_ptr_q, 0);

        // Simultaneous credit and transfer, then overflow
        bus.credit_i = 1'b1;
        tick();
        bus.credit_i = 1'b1;
        tick();
        chk("t4_credits2", dut.credits_q, 2);
        push(0, 16'h8020);
        push(0, 16'h4021);
        drive();
        #1;
        tick();
        chk("t4_shift", bus.shift_o, 4'b0001);
        bus.credit_i = 1'b1;
        tick();
        chk("t4_both_credits", dut.credits_q, 2);
        chk("t4_both_data", bus.data_o, 16'h8020);
        tick();
        chk("t4_tail_data", bus.data_o, 16'h4021);
        chk("t4_after_credits", dut.credits_q, 1);
        for (int i = 0; i < 4; i++) begin
            bus.credit_i = 1'b1;
            tick();
        end
        chk("t4_full_credits", dut.credits_q, 5);
        chk("t4_no_err", bus.credit_err_o, 1'b0);
        bus.credit_i = 1'b1;
        tick();
        chk("t4_err_set", bus.credit_err_o, 1'b1);
        chk("t4_err_credits", dut.credits_q, 5);
        tick();
        tick();
        chk("t4_err_sticky", bus.credit_err_o, 1'b1);

        // Fairness across all four inputs
        do_reset();
        for (int k = 0; k < 4; k++) push(k, 16'hC000 | 16'(k << 4));
        for (int k = 0; k < 4; k++) push(k, 16'hC001 | 16'(k << 4));
        drive();
        #1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n % 2 == 0) begin
                chk($sformatf("t5_valid%0d", n), bus.valid_o, 1'b1);
                chk($sformatf("t5_data%0d", n), bus.data_o, e5_dat[n/2 - 1]);
            end else begin
                chk($sformatf("t5_gap%0d", n), bus.valid_o, 1'b0);
            end
        end
        tick();
        chk("t5_nocredit_busy", bus.busy_o, 1'b1);
        chk("t5_nocredit_shift", bus.shift_o, 4'b0000);

        // Asynchronous reset mid-packet
        do_reset();
        push(1, 16'h8030);
        push(1, 16'h0031);
        push(1, 16'h0032);
        push(1, 16'h4033);
        drive();
        #1;
        tick();
        tick();
        tick();
        chk("t6_pre_data", bus.data_o, 16'h0031);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", bus.valid_o, 1'b0);
        chk("t6_async_data", bus.data_o, 16'h0000);
        chk("t6_async_busy", bus.busy_o, 1'b0);
        chk("t6_async_shift", bus.shift_o, 4'b0000);
        chk("t6_async_credits", dut.credits_q, 5);
        clear_q();
        push(2, 16'hC040);
        drive();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tick();
        chk("t6_new_busy", bus.busy_o, 1'b1);
        chk("t6_new_shift", bus.shift_o, 4'b0100);
        tick();
        chk("t6_new_valid", bus.valid_o, 1'b1);
        chk("t6_new_data", bus.data_o, 16'hC040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
